// File: rtl/fmadd_pn_mul_pipe_if.sv
// Handshake bundle between the FMADD multiplier array, the post-normalizer and the adder/rounding stages.
// master drives the operation into the block and consumes its result; slave is the post-normalizer.
interface fmadd_pn_mul_pipe_if #(
  parameter int MAN   = 22,
  parameter int EXP   = 7,
  parameter int TAG_W = 4
);
  localparam int P = 2*MAN+4;

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic               in_sign;
  logic [EXP+1:0]     in_exp_db;
  logic [P-1:0]       in_man;
  logic [2:0]         in_rm;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [EXP+P+2:0]   out_no;
  logic               out_sticky;
  logic               out_zero_unrounded;
  logic               out_ovf;
  logic [2:0]         out_rm;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output flush, in_valid, in_sign, in_exp_db, in_man, in_rm, in_tag, out_ready,
    input  in_ready, out_valid, out_no, out_sticky, out_zero_unrounded, out_ovf, out_rm, out_tag
  );

  modport slave (
    input  flush, in_valid, in_sign, in_exp_db, in_man, in_rm, in_tag, out_ready,
    output in_ready, out_valid, out_no, out_sticky, out_zero_unrounded, out_ovf, out_rm, out_tag
  );
endinterface

// File: rtl/fmadd_pn_mul_pipe.sv
// Two-stage FMADD multiply post-normalizer: S1 captures the product and its leading-zero count,
// S2 normalizes to normal/subnormal/zero and holds the unrounded result for the adder/rounding stages.
module fmadd_pn_mul_pipe #(
  parameter int STD   = 31,
  parameter int MAN   = 22,
  parameter int EXP   = 7,
  parameter int BIAS  = 127,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fmadd_pn_mul_pipe_if.slave    bus
);
  localparam int P    = 2*MAN+4;
  localparam int SH_W = $clog2(P+1);
  localparam int E3   = EXP+3;
  localparam logic signed [E3-1:0] BIAS_S  = E3'(BIAS);
  localparam logic signed [E3-1:0] P_S     = E3'(P);
  localparam logic signed [E3-1:0] OVF_LIM = E3'((1 << (EXP+1)) - 1);

  if (STD != EXP + MAN + 2) begin : g_bad_params
    $error("fmadd_pn_mul_pipe: STD must equal EXP+MAN+2");
  end

  logic               s1_valid;
  logic               s1_sign;
  logic [EXP+1:0]     s1_exp_db;
  logic [P-1:0]       s1_man;
  logic [2:0]         s1_rm;
  logic [TAG_W-1:0]   s1_tag;
  logic [SH_W-1:0]    s1_lz;

  logic               out_valid_q;
  logic               out_sign_q;
  logic [EXP+1:0]     out_exp_q;
  logic [P-1:0]       out_man_q;
  logic               out_sticky_q;
  logic               out_zero_q;
  logic               out_ovf_q;
  logic [2:0]         out_rm_q;
  logic [TAG_W-1:0]   out_tag_q;

  logic adv1, adv2;
  assign adv2 = ~out_valid_q | bus.out_ready;
  assign adv1 = ~s1_valid | adv2;
  assign bus.in_ready = adv1;

  logic [SH_W-1:0] lz_in;
  always_comb begin
    lz_in = SH_W'(P);
    for (int i = 0; i < P; i++) begin
      if (bus.in_man[i]) lz_in = SH_W'(P-1-i);
    end
  end

  logic signed [E3-1:0] k, e_norm, neg_k;
  logic [SH_W-1:0]      sh_r;
  logic [2*P-1:0]       wide;
  logic [EXP+1:0]       nx_exp;
  logic [P-1:0]         nx_man;
  logic                 nx_sticky, nx_ovf, nx_zero;

  always_comb begin
    k      = $signed({1'b0, s1_exp_db}) - BIAS_S;
    e_norm = k + E3'(1) - $signed({{(E3-SH_W){1'b0}}, s1_lz});
    neg_k  = -k;
    sh_r   = (neg_k > P_S) ? SH_W'(P) : neg_k[SH_W-1:0];
    // Right shift into a double-width window; whatever lands in the low half was shifted out.
    wide   = {s1_man, {P{1'b0}}} >> sh_r;
    nx_exp    = '0;
    nx_man    = '0;
    nx_sticky = 1'b0;
    nx_ovf    = 1'b0;
    if (s1_man == '0) begin
      nx_man = '0;
    end else if (!e_norm[E3-1] && (e_norm != '0)) begin
      nx_man = s1_man << s1_lz;
      nx_exp = e_norm[EXP+1:0];
      nx_ovf = (e_norm >= OVF_LIM);
    end else if (!k[E3-1]) begin
      nx_man = s1_man << k[SH_W-1:0];
    end else begin
      nx_man    = wide[2*P-1:P];
      nx_sticky = |wide[P-1:0];
    end
    nx_zero = (nx_man == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_sign      <= 1'b0;
      s1_exp_db    <= '0;
      s1_man       <= '0;
      s1_rm        <= '0;
      s1_tag       <= '0;
      s1_lz        <= '0;
      out_valid_q  <= 1'b0;
      out_sign_q   <= 1'b0;
      out_exp_q    <= '0;
      out_man_q    <= '0;
      out_sticky_q <= 1'b0;
      out_zero_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_rm_q     <= '0;
      out_tag_q    <= '0;
    end else begin
      if (bus.flush)  s1_valid <= 1'b0;
      else if (adv1)  s1_valid <= bus.in_valid;
      if (adv1 && bus.in_valid) begin
        s1_sign   <= bus.in_sign;
        s1_exp_db <= bus.in_exp_db;
        s1_man    <= bus.in_man;
        s1_rm     <= bus.in_rm;
        s1_tag    <= bus.in_tag;
        s1_lz     <= lz_in;
      end
      if (bus.flush)  out_valid_q <= 1'b0;
      else if (adv2)  out_valid_q <= s1_valid;
      if (adv2 && s1_valid) begin
        out_sign_q   <= s1_sign;
        out_exp_q    <= nx_exp;
        out_man_q    <= nx_man;
        out_sticky_q <= nx_sticky;
        out_zero_q   <= nx_zero;
        out_ovf_q    <= nx_ovf;
        out_rm_q     <= s1_rm;
        out_tag_q    <= s1_tag;
      end
    end
  end

  assign bus.out_valid          = out_valid_q;
  assign bus.out_no             = {out_sign_q, out_exp_q, out_man_q};
  assign bus.out_sticky         = out_sticky_q;
  assign bus.out_zero_unrounded = out_zero_q;
  assign bus.out_ovf            = out_ovf_q;
  assign bus.out_rm             = out_rm_q;
  assign bus.out_tag            = out_tag_q;
endmodule

// File: tb/tb_fmadd_pn_mul_pipe.sv
// Directed bench for the fp32 post-normalizer: vector table plus backpressure, flush and reset sequences.
module tb_fmadd_pn_mul_pipe;
  localparam int MAN = 22, EXP = 7, TAG_W = 4, P = 2*MAN+4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fmadd_pn_mul_pipe_if #(.MAN(MAN), .EXP(EXP), .TAG_W(TAG_W)) bus ();

  fmadd_pn_mul_pipe #(.STD(31), .MAN(MAN), .EXP(EXP), .BIAS(127), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        sign;
    logic [8:0]  exp_db;
    logic [47:0] man;
    logic [2:0]  rm;
    logic [3:0]  tag;
    logic [8:0]  e_exp;
    logic [47:0] e_man;
    logic        e_sticky;
    logic        e_zero;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[13];
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [57:0] bp_model(input int tag);
    logic [8:0] e;
    e = 9'(127 + tag);
    return {1'b0, e, 48'h800000000000};
  endfunction

  initial begin
    vecs[0]  = '{1'b0, 9'd254, 48'h400000000000, 3'd0, 4'd1,  9'd127, 48'h800000000000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 9'd254, 48'h900000000000, 3'd1, 4'd2,  9'd128, 48'h900000000000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 9'd103, 48'h400000000000, 3'd2, 4'd3,  9'd0,   48'h000000400000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 9'd103, 48'h400000000001, 3'd3, 4'd4,  9'd0,   48'h000000400000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 9'd60,  48'h400000000000, 3'd4, 4'd5,  9'd0,   48'h000000000000, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 9'd254, 48'h000000000000, 3'd5, 4'd6,  9'd0,   48'h000000000000, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 9'd382, 48'h400000000000, 3'd6, 4'd7,  9'd255, 48'h800000000000, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 9'd381, 48'h400000000000, 3'd7, 4'd8,  9'd254, 48'h800000000000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 9'd137, 48'h000000000001, 3'd0, 4'd9,  9'd0,   48'h000000000400, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 9'd127, 48'h400000000000, 3'd1, 4'd10, 9'd0,   48'h400000000000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 9'd128, 48'h400000000000, 3'd2, 4'd11, 9'd1,   48'h800000000000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 9'd80,  48'h800000000000, 3'd3, 4'd12, 9'd0,   48'h000000000001, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 9'd79,  48'h800000000000, 3'd4, 4'd13, 9'd0,   48'h000000000000, 1'b1, 1'b1, 1'b0};

    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp_db = '0;
    bus.in_man    = '0;
    bus.in_rm     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_no", 64'(bus.out_no), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_sign   = vecs[i].sign;
      bus.in_exp_db = vecs[i].exp_db;
      bus.in_man    = vecs[i].man;
      bus.in_rm     = vecs[i].rm;
      bus.in_tag    = vecs[i].tag;
      #1;
      check("vec_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("vec_latency_early", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      check("vec_out_valid", 64'(bus.out_valid), 64'd1);
      check("vec_out_no", 64'(bus.out_no), 64'({vecs[i].sign, vecs[i].e_exp, vecs[i].e_man}));
      check("vec_sticky", 64'(bus.out_sticky), 64'(vecs[i].e_sticky));
      check("vec_zero", 64'(bus.out_zero_unrounded), 64'(vecs[i].e_zero));
      check("vec_ovf", 64'(bus.out_ovf), 64'(vecs[i].e_ovf));
      check("vec_rm", 64'(bus.out_rm), 64'(vecs[i].rm));
      check("vec_tag", 64'(bus.out_tag), 64'(vecs[i].tag));
    end
    @(negedge clk);
    check("vec_drain", 64'(bus.out_valid), 64'd0);

    // Backpressure: out_ready held low for the first 4 cycles of a 5-op stream.
    begin
      int next_tag = 1, exp_tag = 1, acc = 0, cyc = 0, acc_at_stall = -1;
      while (exp_tag <= 5 && cyc < 40) begin
        @(negedge clk);
        bus.out_ready = (cyc >= 4);
        if (next_tag <= 5) begin
          bus.in_valid  = 1'b1;
          bus.in_sign   = 1'b0;
          bus.in_tag    = 4'(next_tag);
          bus.in_exp_db = 9'(254 + next_tag);
          bus.in_man    = 48'h400000000000;
          bus.in_rm     = 3'd0;
        end else begin
          bus.in_valid = 1'b0;
        end
        #1;
        if (bus.out_valid) begin
          check("bp_tag_order", 64'(bus.out_tag), 64'(exp_tag));
          check("bp_out_no", 64'(bus.out_no), 64'(bp_model(exp_tag)));
          if (bus.out_ready) exp_tag++;
        end
        if (bus.in_valid && !bus.in_ready && acc_at_stall < 0) acc_at_stall = acc;
        if (bus.in_valid && bus.in_ready) begin
          next_tag++;
          acc++;
        end
        cyc++;
      end
      check("bp_all_out", 64'(exp_tag), 64'd6);
      check("bp_accepts_before_stall", 64'(acc_at_stall), 64'd2);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("bp_no_duplicate", 64'(bus.out_valid), 64'd0);
    end

    // Flush with both stages full; the op offered on the flush edge must vanish.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_exp_db = 9'd254;
    bus.in_man    = 48'h400000000000;
    bus.in_tag    = 4'd10;
    @(negedge clk);
    bus.in_tag = 4'd11;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("fl_full", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_tag    = 4'd12;
    #1;
    check("fl_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_out_cleared", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fl_dropped", 64'(bus.out_valid), 64'd0);
    end

    // Asynchronous reset with ops in flight.
    bus.in_valid = 1'b1;
    bus.in_tag   = 4'd13;
    @(negedge clk);
    bus.in_tag = 4'd14;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("rs_pre_valid", 64'(bus.out_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rs_async_valid", 64'(bus.out_valid), 64'd0);
    check("rs_async_no", 64'(bus.out_no), 64'd0);
    check("rs_async_tag", 64'(bus.out_tag), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rs_lost", 64'(bus.out_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
